// File: rtl/acc_cpu_fsm.sv
// acc_cpu_fsm: multi-cycle parametrised accumulator processor.
// FETCH/DECODE/MEM sequencing against synchronous instruction ROM and data
// RAM, carry/zero flags, conditional jumps, immediate load, valid/ready I/O
// ports and halt.
// Optional feature macro: CPU_MUL_EN (opcode E = MUL; otherwise E is a NOP).
module acc_cpu_fsm #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 8,
   parameter int RESET_PC = 0
) (
   input  logic                clock,
   input  logic                reset,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic [4+ADDR_W-1:0] imem_rdata,
   output logic [ADDR_W-1:0]   dmem_addr,
   output logic                dmem_we,
   output logic [DATA_W-1:0]   dmem_wdata,
   input  logic [DATA_W-1:0]   dmem_rdata,
   input  logic [DATA_W-1:0]   in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                halted,
   output logic [ADDR_W-1:0]   pc_dbg,
   output logic [4+ADDR_W-1:0] ir_dbg,
   output logic [DATA_W-1:0]   acc_dbg,
   output logic [1:0]          flags_dbg
);

   localparam int IW = 4 + ADDR_W;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_MEM, S_IN_WAIT, S_OUT_WAIT, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0, OP_LDA, OP_STO, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_JMP, OP_JZ, OP_JC, OP_IN, OP_OUT, OP_LDI, OP_MUL, OP_HLT
   } op_t;

   // architectural state
   state_t            state_q, state_n;
   logic [ADDR_W-1:0] pc_q, pc_n;
   logic [IW-1:0]     ir_q, ir_n;
   logic [DATA_W-1:0] acc_q, acc_n;
   logic              c_q, c_n, z_q, z_n;
   logic [DATA_W-1:0] out_data_q, out_data_n;
   logic              out_valid_q, out_valid_n;
   logic              out_load;

   // decode fields: DECODE works on the word arriving from the ROM, MEM on IR
   op_t               dec_op, ir_op;
   logic [ADDR_W-1:0] dec_opnd, ir_opnd;
   logic [DATA_W-1:0] imm;

   assign dec_op   = op_t'(imem_rdata[IW-1 -: 4]);
   assign dec_opnd = imem_rdata[ADDR_W-1:0];
   assign ir_op    = op_t'(ir_q[IW-1 -: 4]);
   assign ir_opnd  = ir_q[ADDR_W-1:0];
   // immediate is zero-extended, or truncated when the operand is wider
   assign imm      = DATA_W'(dec_opnd);

   // ALU datapath; the extra top bit carries out of ADD and borrows out of SUB
   logic [DATA_W:0] sum, diff;
   assign sum  = {1'b0, acc_q} + {1'b0, dmem_rdata};
   assign diff = {1'b0, acc_q} - {1'b0, dmem_rdata};

`ifdef CPU_MUL_EN
   localparam int PW = 2 * DATA_W;
   logic [PW-1:0] prod;
   assign prod = PW'(acc_q) * PW'(dmem_rdata);
`endif

   // memory and port interface
   assign imem_addr  = pc_q;
   // operand comes straight from the ROM in DECODE, from IR afterwards
   assign dmem_addr  = (state_q == S_DECODE) ? dec_opnd : ir_opnd;
   assign dmem_we    = (state_q == S_DECODE) && (dec_op == OP_STO) && !reset;
   assign dmem_wdata = acc_q;
   assign in_ready   = (state_q == S_IN_WAIT) && !reset;
   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign halted     = (state_q == S_HALT);
   assign pc_dbg     = pc_q;
   assign ir_dbg     = ir_q;
   assign acc_dbg    = acc_q;
   assign flags_dbg  = {c_q, z_q};

   // state register; reset overrides every state and handshake
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_FETCH;
         pc_q        <= ADDR_W'(RESET_PC);
         ir_q        <= '0;
         acc_q       <= '0;
         c_q         <= 1'b0;
         z_q         <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_n;
         pc_q        <= pc_n;
         ir_q        <= ir_n;
         acc_q       <= acc_n;
         c_q         <= c_n;
         z_q         <= z_n;
         out_data_q  <= out_data_n;
         out_valid_q <= out_valid_n;
      end
   end

   // next-state, datapath and output-port logic
   always_comb begin
      state_n     = state_q;
      pc_n        = pc_q;
      ir_n        = ir_q;
      acc_n       = acc_q;
      c_n         = c_q;
      z_n         = z_q;
      out_load    = 1'b0;
      out_data_n  = out_data_q;
      out_valid_n = out_valid_q;

      unique case (state_q)
         S_FETCH: state_n = S_DECODE;

         S_DECODE: begin
            ir_n    = imem_rdata;
            pc_n    = pc_q + ADDR_W'(1);
            state_n = S_FETCH;
            case (dec_op)
               OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                  state_n = S_MEM;
               OP_MUL: begin
`ifdef CPU_MUL_EN
                  state_n = S_MEM;
`endif
               end
               OP_JMP: pc_n = dec_opnd;
               OP_JZ:  if (z_q) pc_n = dec_opnd;
               OP_JC:  if (c_q) pc_n = dec_opnd;
               OP_IN:  state_n = S_IN_WAIT;
               // a still-pending output value forces a stall
               OP_OUT: begin
                  if (!out_valid_q) out_load = 1'b1;
                  else              state_n  = S_OUT_WAIT;
               end
               OP_LDI: begin
                  acc_n = imm;
                  z_n   = (imm == '0);
               end
               OP_HLT: state_n = S_HALT;
               default: ;
            endcase
         end

         // read data is back from the RAM: finish the ALU op
         S_MEM: begin
            state_n = S_FETCH;
            case (ir_op)
               OP_LDA: acc_n = dmem_rdata;
               OP_ADD: {c_n, acc_n} = sum;
               OP_SUB: begin
                  acc_n = diff[DATA_W-1:0];
                  c_n   = diff[DATA_W];
               end
               OP_AND: acc_n = acc_q & dmem_rdata;
               OP_OR:  acc_n = acc_q | dmem_rdata;
               OP_XOR: acc_n = acc_q ^ dmem_rdata;
`ifdef CPU_MUL_EN
               OP_MUL: begin
                  acc_n = prod[DATA_W-1:0];
                  c_n   = |prod[PW-1:DATA_W];
               end
`endif
               default: ;
            endcase
            z_n = (acc_n == '0);
         end

         S_IN_WAIT: begin
            if (in_valid) begin
               acc_n   = in_data;
               z_n     = (in_data == '0);
               state_n = S_FETCH;
            end
         end

         // the old value may be consumed this very cycle, so load on ready
         S_OUT_WAIT: begin
            if (!out_valid_q || out_ready) begin
               out_load = 1'b1;
               state_n  = S_FETCH;
            end
         end

         S_HALT: ;

         default: state_n = S_FETCH;
      endcase

      // output register: a new load keeps valid high, else a handshake clears it
      if (out_load) begin
         out_data_n  = acc_q;
         out_valid_n = 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_n = 1'b0;
      end
   end

endmodule

// File: tb/tb_acc_cpu_fsm.sv
// tb_acc_cpu_fsm: table-driven program vectors plus hand-written sequences
// for reset, cycle timing, input stall, output back-pressure and reset escape.
module tb_acc_cpu_fsm;

   localparam logic [11:0] H = 12'hF00;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  imem_addr;
   logic [11:0] imem_rdata;
   logic [7:0]  dmem_addr;
   logic        dmem_we;
   logic [7:0]  dmem_wdata;
   logic [7:0]  dmem_rdata;
   logic [7:0]  in_data  = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        halted;
   logic [7:0]  pc_dbg;
   logic [11:0] ir_dbg;
   logic [7:0]  acc_dbg;
   logic [1:0]  flags_dbg;

   acc_cpu_fsm dut (
      .clock(clock), .reset(reset),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .halted(halted), .pc_dbg(pc_dbg), .ir_dbg(ir_dbg), .acc_dbg(acc_dbg),
      .flags_dbg(flags_dbg)
   );

   always #5 clock = ~clock;

   // synchronous memories; RAM contents set by the stimulus, stores logged
   logic [11:0] rom [256];
   logic [7:0]  ram [256];
   logic [7:0]  last_wa, last_wv;
   logic [7:0]  cap_q[$];

   always @(posedge clock) begin
      imem_rdata <= rom[imem_addr];
      dmem_rdata <= ram[dmem_addr];
      if (dmem_we) begin
         last_wa <= dmem_addr;
         last_wv <= dmem_wdata;
      end
      if (out_valid && out_ready) cap_q.push_back(out_data);
   end

   typedef struct {
      logic [4:0][11:0] prog;     // prog[0] at address 0
      logic [7:0] ma0, mv0, ma1, mv1;
      logic [7:0] acc;
      logic       c, z;
      logic [7:0] pc;
      int         we;
      logic [7:0] wa, wv;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic load(input vec_t v);
      for (int i = 0; i < 256; i++) begin
         rom[i] = H;
         ram[i] = 8'h00;
      end
      for (int i = 0; i < 5; i++) rom[i] = v.prog[i];
      ram[v.ma0] = v.mv0;
      ram[v.ma1] = v.mv1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic run_to_halt(input int max, output int cyc, output int we_n,
                              output int ov_n);
      cyc = 0; we_n = 0; ov_n = 0;
      while (!halted && cyc < max) begin
         @(posedge clock);
         #1;
         cyc++;
         if (dmem_we) we_n++;
         if (out_valid) ov_n++;
      end
   endtask

   function automatic logic [4:0][11:0] P(input logic [11:0] a, b, c, d, e);
      P = {e, d, c, b, a};
   endfunction

   vec_t vt[12];
   vec_t hv;
   int cyc, we_n, ov_n, cap0, rdy;

   initial begin
      //       program                               ma0 mv0  ma1 mv1  acc  c z  pc   we wa  wv
      vt[0]  = '{P(12'hD05,12'hC00,H,H,H),          0,  0,   0,  0,  5,   0,0, 3,   0, 0,  0};
      vt[1]  = '{P(12'h10A,12'h30B,12'h20C,H,H),    10, 200, 11, 100,44,  1,0, 4,   1, 12, 44};
      vt[2]  = '{P(12'hD03,12'h414,12'h907,H,H),    20, 3,   0,  0,  0,   0,1, 8,   0, 0,  0};
      vt[3]  = '{P(12'hD03,12'h414,12'h907,H,H),    20, 4,   0,  0,  255, 1,0, 4,   0, 0,  0};
      vt[4]  = '{P(12'hD0F,12'h51E,H,H,H),          30, 8'h3C,0, 0,  8'h0C,0,0,3,   0, 0,  0};
      vt[5]  = '{P(12'hDF0,12'h61E,12'h71F,H,H),    30, 8'h0F,31,8'hFF,0, 0,1, 4,   0, 0,  0};
      vt[6]  = '{P(12'h805,H,H,H,H),                0,  0,   0,  0,  0,   0,0, 6,   0, 0,  0};
      vt[7]  = '{P(12'hDC8,12'h30A,12'hA06,H,H),    10, 100, 0,  0,  44,  1,0, 7,   0, 0,  0};
      vt[8]  = '{P(12'hD01,12'h30A,12'hA06,H,H),    10, 1,   0,  0,  2,   0,0, 4,   0, 0,  0};
      vt[9]  = '{P(12'hD00,12'h000,H,H,H),          0,  0,   0,  0,  0,   0,1, 3,   0, 0,  0};
`ifdef CPU_MUL_EN
      vt[10] = '{P(12'hD10,12'hE10,H,H,H),          16, 16,  0,  0,  0,   1,1, 3,   0, 0,  0};
`else
      vt[10] = '{P(12'hD10,12'hE10,H,H,H),          16, 16,  0,  0,  16,  0,0, 3,   0, 0,  0};
`endif
      // jump to the last address; HLT there wraps PC to 0
      vt[11] = '{P(12'h8FF,H,H,H,H),                0,  0,   0,  0,  0,   0,0, 0,   0, 0,  0};

      // ---- reset state, then cycle-exact LDI 5; OUT; HLT ----
      load(vt[0]);
      out_ready = 1'b1;
      do_reset();
      chk("rst_pc", -1, pc_dbg, 0);
      chk("rst_ir", -1, ir_dbg, 0);
      chk("rst_acc", -1, acc_dbg, 0);
      chk("rst_flags", -1, flags_dbg, 0);
      chk("rst_outv", -1, out_valid, 0);
      chk("rst_outd", -1, out_data, 0);
      chk("rst_inrdy", -1, in_ready, 0);
      chk("rst_we", -1, dmem_we, 0);
      chk("rst_halt", -1, halted, 0);
      cap0 = cap_q.size();
      run_to_halt(100, cyc, we_n, ov_n);
      chk("halt_cycles", -1, cyc, 6);
      chk("halt_pc", -1, pc_dbg, 3);
      chk("out_pulse", -1, ov_n, 1);
      chk("out_count", -1, cap_q.size() - cap0, 1);
      if (cap_q.size() > cap0) chk("out_val", -1, cap_q[cap0], 5);

      // ---- table of programs ----
      for (int i = 0; i < 12; i++) begin
         load(vt[i]);
         do_reset();
         run_to_halt(200, cyc, we_n, ov_n);
         chk("halted", i, halted, 1);
         chk("acc", i, acc_dbg, vt[i].acc);
         chk("flags", i, flags_dbg, {vt[i].c, vt[i].z});
         chk("pc", i, pc_dbg, vt[i].pc);
         chk("we_cycles", i, we_n, vt[i].we);
         if (vt[i].we > 0) begin
            chk("st_addr", i, last_wa, vt[i].wa);
            chk("st_data", i, last_wv, vt[i].wv);
         end
      end

      // ---- IN with input withheld for 5 cycles ----
      hv = vt[0];
      hv.prog = P(12'hB00, H, H, H, H);
      load(hv);
      in_valid = 1'b0;
      do_reset();
      repeat (2) @(posedge clock);
      #1;
      rdy = 0;
      for (int k = 0; k < 5; k++) begin
         if (in_ready) rdy++;
         @(posedge clock);
         #1;
      end
      chk("in_wait_rdy", -1, rdy, 5);
      in_data = 8'h2A;
      in_valid = 1'b1;
      @(posedge clock);
      #1 in_valid = 1'b0;
      chk("in_acc", -1, acc_dbg, 8'h2A);
      chk("in_rdy_drop", -1, in_ready, 0);
      run_to_halt(50, cyc, we_n, ov_n);
      chk("in_pc", -1, pc_dbg, 2);

      // ---- back-to-back OUT against a stalled consumer ----
      hv.prog = P(12'hD01, 12'hC00, 12'hD02, 12'hC00, H);
      load(hv);
      out_ready = 1'b0;
      do_reset();
      cap0 = cap_q.size();
      repeat (20) @(posedge clock);
      #1;
      chk("stall_halt", -1, halted, 0);
      chk("stall_pc", -1, pc_dbg, 4);
      chk("stall_outd", -1, out_data, 1);
      chk("stall_outv", -1, out_valid, 1);
      out_ready = 1'b1;
      run_to_halt(50, cyc, we_n, ov_n);
      chk("bb_halted", -1, halted, 1);
      chk("bb_count", -1, cap_q.size() - cap0, 2);
      if (cap_q.size() >= cap0 + 2) begin
         chk("bb_first", -1, cap_q[cap0], 1);
         chk("bb_second", -1, cap_q[cap0+1], 2);
      end
      chk("bb_outv_end", -1, out_valid, 0);

      // ---- reset during IN_WAIT with input offered ----
      hv.prog = P(12'hB00, H, H, H, H);
      load(hv);
      do_reset();
      repeat (2) @(posedge clock);
      #1;
      chk("inw_rdy", -1, in_ready, 1);
      in_data = 8'h55;
      in_valid = 1'b1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("inw_rst_acc", -1, acc_dbg, 0);
      chk("inw_rst_pc", -1, pc_dbg, 0);
      in_valid = 1'b0;
      reset = 1'b0;
      @(posedge clock);
      #1;
      chk("inw_rst_rdy", -1, in_ready, 0);
      @(posedge clock);
      #1;
      chk("refetch_ir", -1, ir_dbg, 12'hB00);
      chk("refetch_pc", -1, pc_dbg, 1);

      // ---- reset while halted with output still pending ----
      hv.prog = P(12'hD09, 12'hC00, H, H, H);
      load(hv);
      out_ready = 1'b0;
      do_reset();
      run_to_halt(50, cyc, we_n, ov_n);
      chk("h_halted", -1, halted, 1);
      chk("h_outv", -1, out_valid, 1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("hr_halted", -1, halted, 0);
      chk("hr_outv", -1, out_valid, 0);
      chk("hr_outd", -1, out_data, 0);
      chk("hr_acc", -1, acc_dbg, 0);
      chk("hr_pc", -1, pc_dbg, 0);
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/acc_cpu_fsm.md
Name: acc_cpu_fsm

Overview:
- Multi-cycle, parametrised accumulator processor; next generation of the single-cycle accumulator CPU.
- Adds generic data/address widths, a FETCH/DECODE/MEM FSM against synchronous external memories, carry/zero flags, conditional jumps, immediate load, valid/ready I/O ports and halt.
- Sits between an instruction ROM, a data RAM and the board I/O; debug taps expose PC, IR and ACC.

Parameters:
DATA_W, 8, accumulator / data-memory word width
ADDR_W, 8, PC and operand address width; instruction word = {opcode[3:0], operand[ADDR_W-1:0]}
RESET_PC, 0, PC value loaded on reset

Ports:
clock  in  1  single system clock, all state on rising edge
reset  in  1  synchronous, active-high
imem_addr  out  ADDR_W  instruction address (= PC)
imem_rdata  in  4+ADDR_W  instruction, valid 1 cycle after imem_addr
dmem_addr  out  ADDR_W  data address (= IR operand)
dmem_we  out  1  data write strobe, one cycle
dmem_wdata  out  DATA_W  write data (= ACC)
dmem_rdata  in  DATA_W  read data, valid 1 cycle after dmem_addr
in_data  in  DATA_W  input port data
in_valid  in  1  input data available
in_ready  out  1  CPU accepting input
out_data  out  DATA_W  output port register
out_valid  out  1  out_data pending
out_ready  in  1  consumer accepts out_data
halted  out  1  CPU in HALT state
pc_dbg  out  ADDR_W  current PC
ir_dbg  out  4+ADDR_W  current IR
acc_dbg  out  DATA_W  current ACC
flags_dbg  out  2  {C, Z}

Behaviour:
- Reset (sync, high): PC=RESET_PC, IR=0, ACC=0, C=0, Z=0, out_data=0, out_valid=0, in_ready=0, dmem_we=0, halted=0, state=FETCH. Reset wins over every other event in any state, including mid-handshake and HALT.
- States: FETCH, DECODE, MEM, IN_WAIT, OUT_WAIT, HALT.
- FETCH: imem_addr=PC; next DECODE.
- DECODE: IR<=imem_rdata (visible on ir_dbg next cycle); opcode decoded from imem_rdata same cycle. PC<=PC+1 (mod 2^ADDR_W, wraps) unless a jump is taken.
- Opcodes: 0 NOP; 1 LDA; 2 STO; 3 ADD; 4 SUB; 5 AND; 6 OR; 7 XOR; 8 JMP; 9 JZ; A JC; B IN; C OUT; D LDI; E MUL (optional); F HLT.
- Memory-read ops (1,3-7): DECODE drives dmem_addr=operand, -> MEM; in MEM: ACC<=f(ACC, dmem_rdata), -> FETCH. 3 cycles/instruction.
- STO: DECODE asserts dmem_we=1, dmem_addr=operand, dmem_wdata=ACC for that one cycle; -> FETCH.
- LDI: ACC<=zero-extended operand (truncated if ADDR_W>DATA_W); -> FETCH.
- JMP: PC<=operand. JZ: PC<=operand if Z=1. JC: PC<=operand if C=1. Untaken -> PC+1. 2 cycles/instruction.
- ADD: {C,ACC}<=ACC+mem (DATA_W+1 bits). SUB: ACC<=ACC-mem mod 2^DATA_W; C=1 iff borrow (ACC<mem unsigned). AND/OR/XOR/LDA: C unchanged.
- Z<=(new ACC==0) on LDA, LDI, ADD, SUB, AND, OR, XOR, IN, MUL. STO, OUT, jumps, NOP leave flags unchanged.
- IN: -> IN_WAIT, in_ready=1; on in_valid&in_ready: ACC<=in_data, update Z, in_ready<=0, -> FETCH. Waits indefinitely.
- OUT: if out_valid=0: out_data<=ACC, out_valid<=1, -> FETCH. If out_valid=1 (previous value unconsumed): -> OUT_WAIT, stall until out_ready, then load new value, keep out_valid=1, -> FETCH. Independently, out_valid clears on out_valid&out_ready when no new load occurs the same cycle.
- HLT: -> HALT, halted=1, PC frozen; only reset exits. Pending out_valid still completes handshake.

Optional Feature:
CPU_MUL_EN defined: opcode E = MUL, memory-read op; ACC<=low DATA_W bits of ACC*mem; C=1 iff high half nonzero; Z updated. Undefined: opcode E behaves as NOP (2 cycles, no state change except PC).

Test Plan:
- Reset then LDI 5; OUT; HLT with out_ready=1 -> out_data=5, out_valid pulse, halted=1 after 6 cycles, PC=3.
- mem[10]=200, mem[11]=100: LDA 10; ADD 11; STO 12 -> ACC=44, C=1, Z=0, mem[12]=44, dmem_we high exactly 1 cycle.
- LDI 3; SUB 20 (mem[20]=3); JZ 7 -> Z=1, PC=7; repeat with mem[20]=4 -> ACC=255, C=1, JZ untaken, PC=3.
- IN with in_valid low 5 cycles then in_data=0x2A -> in_ready high throughout wait, ACC=0x2A one cycle after handshake.
- Two back-to-back OUTs with out_ready=0 -> CPU stalls in OUT_WAIT; raising out_ready releases; first value 1, second 2 delivered in order.
- Reset asserted mid IN_WAIT and in HALT -> all outputs at reset values next cycle, fetch restarts at RESET_PC; with CPU_MUL_EN, LDI 16; MUL mem=16 -> ACC=0, C=1, Z=1.
